// File: rtl/fetch_seq.sv
// fetch_seq -- instruction-fetch sequencer for the WISC-15 16-bit core.
//
// Owns the architectural fetch PC and issues word-addressed fetches over a
// req/rdy handshake. Presents fetched words to decode with stall/flush
// handling. Applies downstream-resolved redirects (jump, call, return) and
// keeps a circular return-address stack so that returns need not read the
// register file.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   o_imem_req/addr       fetch request and word address (combinational)
//   i_imem_rdy/rdata      memory accept and returned instruction word
//   o_if_valid/instr/pc   fetch-stage output to decode
//   i_stall               decode back-pressure
//   i_redir_*             redirect valid, kind, target, call link
//   i_ret_fallback        return address used when the RAS is empty
//   i_halt                halt reached execute; sticky until reset
//   o_pc, o_halted        current fetch PC, HALTED-state flag
//   o_ras_count           number of live RAS entries
module fetch_seq #(
   parameter int          RAS_DEPTH = 4,
   parameter logic [15:0] RESET_PC  = 16'h0000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   output logic        o_imem_req,
   output logic [15:0] o_imem_addr,
   input  logic        i_imem_rdy,
   input  logic [15:0] i_imem_rdata,
   output logic        o_if_valid,
   output logic [15:0] o_if_instr,
   output logic [15:0] o_if_pc,
   input  logic        i_stall,
   input  logic        i_redir_valid,
   input  logic [1:0]  i_redir_kind,
   input  logic [15:0] i_redir_target,
   input  logic [15:0] i_redir_link,
   input  logic [15:0] i_ret_fallback,
   input  logic        i_halt,
   output logic [15:0] o_pc,
   output logic        o_halted,
   output logic [2:0]  o_ras_count
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_FETCH  = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;

   localparam logic [2:0] LP_DEPTH = 3'(RAS_DEPTH);
   localparam logic [2:0] LP_LAST  = 3'(RAS_DEPTH - 1);

   logic [1:0]  r_state;
   logic [15:0] r_pc;
   logic        r_if_valid;
   logic [15:0] r_if_instr;
   logic [15:0] r_if_pc;
   // Storage is sized to the 3-bit pointer range; only 0..RAS_DEPTH-1 are used.
   logic [15:0] r_ras [0:7];
   logic [2:0]  r_ras_wp;     // next slot to write; top of stack is wp-1
   logic [2:0]  r_ras_count;

   logic        w_stall_eff;
   logic        w_is_call;
   logic        w_is_ret;
   logic [2:0]  w_wp_inc;
   logic [2:0]  w_wp_dec;
   logic [15:0] w_target;

   // A stall only holds the stage when it carries a live instruction.
   assign w_stall_eff = i_stall && r_if_valid;

   assign o_imem_req  = (r_state == ST_FETCH) && !w_stall_eff;
   assign o_imem_addr = r_pc;
   assign o_if_valid  = r_if_valid;
   assign o_if_instr  = r_if_instr;
   assign o_if_pc     = r_if_pc;
   assign o_pc        = r_pc;
   assign o_halted    = (r_state == ST_HALTED);
   assign o_ras_count = r_ras_count;

   assign w_is_call = (i_redir_kind == 2'b01);
   assign w_is_ret  = (i_redir_kind == 2'b10);
   assign w_wp_inc  = (r_ras_wp == LP_LAST) ? 3'd0 : r_ras_wp + 3'd1;
   assign w_wp_dec  = (r_ras_wp == 3'd0) ? LP_LAST : r_ras_wp - 3'd1;

   always_comb begin
      w_target = i_redir_target;
      if (w_is_ret) begin
         w_target = (r_ras_count != 3'd0) ? r_ras[w_wp_dec] : i_ret_fallback;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_pc        <= RESET_PC;
         r_if_valid  <= 1'b0;
         r_if_instr  <= '0;
         r_if_pc     <= '0;
         r_ras_wp    <= '0;
         r_ras_count <= '0;
         for (int i = 0; i < 8; i++) r_ras[i] <= '0;
      end else if (r_state == ST_HALTED) begin
         // Terminal until reset: nothing changes.
         r_if_valid <= 1'b0;
      end else if (i_halt) begin
         r_state    <= ST_HALTED;
         r_if_valid <= 1'b0;
      end else if (i_redir_valid) begin
         // Flush; any data returned this cycle belongs to the abandoned fetch.
         r_state    <= ST_FETCH;
         r_if_valid <= 1'b0;
         r_pc       <= w_target;
         if (w_is_call) begin
            // When full, wp points at the oldest entry, which is overwritten.
            r_ras[r_ras_wp] <= i_redir_link;
            r_ras_wp        <= w_wp_inc;
            if (r_ras_count != LP_DEPTH) r_ras_count <= r_ras_count + 3'd1;
         end else if (w_is_ret && (r_ras_count != 3'd0)) begin
            r_ras_wp    <= w_wp_dec;
            r_ras_count <= r_ras_count - 3'd1;
         end
      end else if (r_state == ST_IDLE) begin
         r_state <= ST_FETCH;
      end else if (!w_stall_eff) begin
         if (i_imem_rdy) begin
            r_if_instr <= i_imem_rdata;
            r_if_pc    <= r_pc;
            r_if_valid <= 1'b1;
            r_pc       <= r_pc + 16'd1;
         end else begin
            r_if_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq -- directed testbench for fetch_seq (RAS_DEPTH=4, RESET_PC=0).
// Instruction memory returns 16'hA000 + address combinationally.
module tb_fetch_seq;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_rdy;
   logic [15:0] imem_rdata;
   logic        if_valid;
   logic [15:0] if_instr;
   logic [15:0] if_pc;
   logic        stall;
   logic        redir_valid;
   logic [1:0]  redir_kind;
   logic [15:0] redir_target;
   logic [15:0] redir_link;
   logic [15:0] ret_fallback;
   logic        halt;
   logic [15:0] pc;
   logic        halted;
   logic [2:0]  ras_count;

   int n_checks;
   int n_fail;

   fetch_seq #(.RAS_DEPTH(4), .RESET_PC(16'h0000)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .o_imem_req     (imem_req),
      .o_imem_addr    (imem_addr),
      .i_imem_rdy     (imem_rdy),
      .i_imem_rdata   (imem_rdata),
      .o_if_valid     (if_valid),
      .o_if_instr     (if_instr),
      .o_if_pc        (if_pc),
      .i_stall        (stall),
      .i_redir_valid  (redir_valid),
      .i_redir_kind   (redir_kind),
      .i_redir_target (redir_target),
      .i_redir_link   (redir_link),
      .i_ret_fallback (ret_fallback),
      .i_halt         (halt),
      .o_pc           (pc),
      .o_halted       (halted),
      .o_ras_count    (ras_count)
   );

   assign imem_rdata = 16'hA000 + imem_addr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench 1ns after the edge on which rst_n was released (IDLE cycle).
   task automatic do_reset();
      rst_n        = 1'b0;
      imem_rdy     = 1'b1;
      stall        = 1'b0;
      redir_valid  = 1'b0;
      redir_kind   = 2'b00;
      redir_target = 16'h0000;
      redir_link   = 16'h0000;
      ret_fallback = 16'h0BAD;
      halt         = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      rst_n = 1'b0;
      #1;
      n_checks++; if (pc !== 16'h0000)     begin n_fail++; $display("FAIL reset_pc got=%h exp=0000", pc); end
      n_checks++; if (imem_req !== 1'b0)   begin n_fail++; $display("FAIL reset_req got=%b exp=0", imem_req); end
      n_checks++; if (imem_addr !== 16'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0000", imem_addr); end
      n_checks++; if (if_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_if_valid got=%b exp=0", if_valid); end
      n_checks++; if (if_instr !== 16'h0)  begin n_fail++; $display("FAIL reset_if_instr got=%h exp=0000", if_instr); end
      n_checks++; if (if_pc !== 16'h0)     begin n_fail++; $display("FAIL reset_if_pc got=%h exp=0000", if_pc); end
      n_checks++; if (halted !== 1'b0)     begin n_fail++; $display("FAIL reset_halted got=%b exp=0", halted); end
      n_checks++; if (ras_count !== 3'd0)  begin n_fail++; $display("FAIL reset_ras_count got=%0d exp=0", ras_count); end
   endtask

   task automatic test_free_run();
      do_reset();
      // Cycle 1: IDLE, no request yet.
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL free_idle_req got=%b exp=0", imem_req); end
      tick();
      // Cycle 2: first request for address 0.
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 16'd0) begin n_fail++; $display("FAIL free_first_req got=%b/%h exp=1/0000", imem_req, imem_addr); end
      n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL free_c2_valid got=%b exp=0", if_valid); end
      for (int k = 1; k <= 5; k++) begin
         tick();
         n_checks++; if (imem_addr !== 16'(k)) begin n_fail++; $display("FAIL free_addr[%0d] got=%h exp=%h", k, imem_addr, 16'(k)); end
         n_checks++; if (if_valid !== 1'b1 || if_pc !== 16'(k - 1) || if_instr !== 16'hA000 + 16'(k - 1))
            begin n_fail++; $display("FAIL free_if[%0d] got=%b/%h/%h exp=1/%h/%h", k, if_valid, if_pc, if_instr, 16'(k - 1), 16'hA000 + 16'(k - 1)); end
      end
   endtask

   task automatic test_rdy_low();
      do_reset();
      tick();
      repeat (5) tick();
      n_checks++; if (imem_addr !== 16'd5) begin n_fail++; $display("FAIL rdy_pre_addr got=%h exp=0005", imem_addr); end
      imem_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (imem_req !== 1'b1 || imem_addr !== 16'd5) begin n_fail++; $display("FAIL rdy_low_req[%0d] got=%b/%h exp=1/0005", i, imem_req, imem_addr); end
         if (i > 0) begin
            n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rdy_low_valid[%0d] got=%b exp=0", i, if_valid); end
         end
         tick();
      end
      n_checks++; if (if_valid !== 1'b0 || pc !== 16'd5) begin n_fail++; $display("FAIL rdy_low_end got=%b/%h exp=0/0005", if_valid, pc); end
      imem_rdy = 1'b1;
      tick();
      n_checks++; if (pc !== 16'd6) begin n_fail++; $display("FAIL rdy_accept_pc got=%h exp=0006", pc); end
      n_checks++; if (if_valid !== 1'b1 || if_pc !== 16'd5 || if_instr !== 16'hA005) begin n_fail++; $display("FAIL rdy_accept_if got=%b/%h/%h exp=1/0005/a005", if_valid, if_pc, if_instr); end
   endtask

   task automatic test_stall_redirect();
      do_reset();
      tick();
      repeat (5) tick();
      n_checks++; if (if_pc !== 16'd4 || if_valid !== 1'b1) begin n_fail++; $display("FAIL stall_pre got=%b/%h exp=1/0004", if_valid, if_pc); end
      stall = 1'b1;
      #1;
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req_gate got=%b exp=0", imem_req); end
      for (int i = 0; i < 2; i++) begin
         tick();
         n_checks++; if (if_valid !== 1'b1 || if_pc !== 16'd4 || if_instr !== 16'hA004) begin n_fail++; $display("FAIL stall_hold[%0d] got=%b/%h/%h exp=1/0004/a004", i, if_valid, if_pc, if_instr); end
         n_checks++; if (imem_req !== 1'b0 || pc !== 16'd5) begin n_fail++; $display("FAIL stall_req[%0d] got=%b/%h exp=0/0005", i, imem_req, pc); end
      end
      redir_valid  = 1'b1;
      redir_kind   = 2'b00;
      redir_target = 16'h0040;
      tick();
      redir_valid = 1'b0;
      // Stall still high, but the flushed stage no longer blocks.
      n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush got=%b exp=0", if_valid); end
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin n_fail++; $display("FAIL redir_fetch got=%b/%h exp=1/0040", imem_req, imem_addr); end
      stall = 1'b0;
      tick();
      n_checks++; if (if_valid !== 1'b1 || if_pc !== 16'h0040 || if_instr !== 16'hA040) begin n_fail++; $display("FAIL redir_first got=%b/%h/%h exp=1/0040/a040", if_valid, if_pc, if_instr); end
   endtask

   task automatic test_ras();
      logic [15:0] exp_ret [0:4];
      logic [2:0]  exp_cnt [0:4];
      exp_ret = '{16'd50, 16'd40, 16'd30, 16'd20, 16'h0BAD};
      exp_cnt = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
      do_reset();
      tick();
      for (int i = 0; i < 5; i++) begin
         redir_valid  = 1'b1;
         redir_kind   = 2'b01;
         redir_target = 16'h0100 + 16'(i);
         redir_link   = 16'(10 * (i + 1));
         tick();
         n_checks++; if (pc !== 16'h0100 + 16'(i)) begin n_fail++; $display("FAIL call_pc[%0d] got=%h exp=%h", i, pc, 16'h0100 + 16'(i)); end
         n_checks++; if (ras_count !== ((i < 4) ? 3'(i + 1) : 3'd4)) begin n_fail++; $display("FAIL call_count[%0d] got=%0d exp=%0d", i, ras_count, (i < 4) ? i + 1 : 4); end
      end
      ret_fallback = 16'h0BAD;
      for (int i = 0; i < 5; i++) begin
         redir_valid  = 1'b1;
         redir_kind   = 2'b10;
         redir_target = 16'h7777;
         tick();
         n_checks++; if (pc !== exp_ret[i]) begin n_fail++; $display("FAIL ret_pc[%0d] got=%h exp=%h", i, pc, exp_ret[i]); end
         n_checks++; if (ras_count !== exp_cnt[i]) begin n_fail++; $display("FAIL ret_count[%0d] got=%0d exp=%0d", i, ras_count, exp_cnt[i]); end
      end
      redir_valid = 1'b0;
   endtask

   task automatic test_halt();
      do_reset();
      tick();
      repeat (3) tick();
      n_checks++; if (pc !== 16'd3) begin n_fail++; $display("FAIL halt_pre_pc got=%h exp=0003", pc); end
      halt         = 1'b1;
      redir_valid  = 1'b1;
      redir_kind   = 2'b01;
      redir_target = 16'h0100;
      redir_link   = 16'h0077;
      tick();
      halt = 1'b0;
      n_checks++; if (halted !== 1'b1 || pc !== 16'd3) begin n_fail++; $display("FAIL halt_enter got=%b/%h exp=1/0003", halted, pc); end
      n_checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0 || ras_count !== 3'd0) begin n_fail++; $display("FAIL halt_quiet got=%b/%b/%0d exp=0/0/0", imem_req, if_valid, ras_count); end
      // Redirects stay ignored while halted.
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++; if (halted !== 1'b1 || pc !== 16'd3 || imem_req !== 1'b0) begin n_fail++; $display("FAIL halt_hold[%0d] got=%b/%h/%b exp=1/0003/0", i, halted, pc, imem_req); end
      end
      redir_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++; if (pc !== 16'h0000 || halted !== 1'b0) begin n_fail++; $display("FAIL halt_async_rst got=%h/%b exp=0000/0", pc, halted); end
      tick();
      rst_n = 1'b1;
      tick();
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin n_fail++; $display("FAIL halt_restart got=%b/%h exp=1/0000", imem_req, imem_addr); end
   endtask

   task automatic test_wrap();
      do_reset();
      tick();
      redir_valid  = 1'b1;
      redir_kind   = 2'b11;
      redir_target = 16'hFFFF;
      redir_link   = 16'h1234;
      tick();
      redir_valid = 1'b0;
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_first got=%b/%h exp=1/ffff", imem_req, imem_addr); end
      n_checks++; if (ras_count !== 3'd0) begin n_fail++; $display("FAIL wrap_kind11_ras got=%0d exp=0", ras_count); end
      tick();
      n_checks++; if (imem_addr !== 16'h0000) begin n_fail++; $display("FAIL wrap_addr got=%h exp=0000", imem_addr); end
      n_checks++; if (if_valid !== 1'b1 || if_pc !== 16'hFFFF || if_instr !== 16'h9FFF) begin n_fail++; $display("FAIL wrap_if got=%b/%h/%h exp=1/ffff/9fff", if_valid, if_pc, if_instr); end
      tick();
      n_checks++; if (imem_addr !== 16'h0001 || if_pc !== 16'h0000 || if_instr !== 16'hA000) begin n_fail++; $display("FAIL wrap_next got=%h/%h/%h exp=0001/0000/a000", imem_addr, if_pc, if_instr); end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_free_run();
      test_rdy_low();
      test_stall_redirect();
      test_ras();
      test_halt();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fetch_seq.md
# fetch_seq

Instruction-fetch sequencer for the WISC-15 16-bit core. It owns the architectural PC register and issues word-addressed fetches to instruction memory over a request/ready handshake. It presents fetched instructions to decode with a stall/flush protocol. It applies control-flow redirects (taken branch, call, return) resolved downstream, and keeps a small return-address stack (RAS) so returns do not wait on the register file.

## Interface
- RAS_DEPTH, 4, number of RAS entries; legal range 1..7.
- RESET_PC, 16'h0000, PC loaded on reset.

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  16  word address of the fetch.
- imem_rdy  in  1  memory accepts the request and returns data this cycle.
- imem_rdata  in  16  instruction word; valid when imem_req && imem_rdy.
- if_valid  out  1  if_instr/if_pc hold a live instruction for decode.
- if_instr  out  16  fetched instruction.
- if_pc  out  16  address of if_instr.
- stall  in  1  decode cannot accept; hold if_* stage.
- redir_valid  in  1  redirect from execute this cycle.
- redir_kind  in  2  00 branch/jump, 01 call, 10 return, 11 treated as 00.
- redir_target  in  16  target for kinds 00/01/11.
- redir_link  in  16  return address pushed on call (call PC + 1).
- ret_fallback  in  16  return-register value used when RAS is empty.
- halt  in  1  halt instruction reached execute.
- pc  out  16  current fetch PC.
- halted  out  1  high in HALTED state.
- ras_count  out  3  valid RAS entries, 0..RAS_DEPTH.

## Operation
- States: IDLE, FETCH, HALTED. Reset enters IDLE. IDLE always goes to FETCH after one cycle. HALTED is left only by reset.
- Each cycle, priority is halt > redir_valid > stall > normal fetch.
- halt: next state HALTED. if_valid<=0 and pc is held. Any same-cycle redirect is ignored, and the RAS is unchanged.
- Redirect, in any state except HALTED:
  - if_valid<=0 (flush).
  - Any outstanding fetch is abandoned; imem_rdata that returns in that cycle is discarded.
  - pc<=target.
  - Next state is FETCH.
- Redirect kinds:
  - Kind 00/11: target=redir_target.
  - Kind 01: target=redir_target, and redir_link is pushed.
  - Kind 10: target=RAS top and the entry is popped. If ras_count==0, target=ret_fallback and the count stays 0.
- RAS full push: the oldest entry is overwritten (circular buffer) and ras_count saturates at RAS_DEPTH. Pops after this return the newest entries first; the lost oldest entry falls back to ret_fallback once the count reaches 0.
- Stall with if_valid=1: if_* and pc are held and imem_req=0.
- Stall with if_valid=0: treated as no stall.
- Normal fetch in FETCH: imem_req=1, imem_addr=pc.
  - On imem_rdy=1: if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+1.
  - On imem_rdy=0: if_valid<=0 and pc is held. The request stays asserted with imem_addr unchanged until accepted or a redirect/halt occurs.
- Arithmetic: pc+1 is modulo 2^16, so 16'hFFFF wraps to 16'h0000. No signed handling is needed; targets arrive fully computed.

## Timing
- Reset values, applied asynchronously while rst_n=0:
  - pc=RESET_PC, state IDLE.
  - imem_req=0, imem_addr=RESET_PC.
  - if_valid=0, if_instr=0, if_pc=0.
  - halted=0, ras_count=0; RAS entries are 0.
- Fetch latency: the first imem_req is asserted in the second cycle after rst_n deasserts (IDLE takes one cycle).
- With imem_rdy tied high and no stall, throughput is one instruction per cycle. if_valid rises the cycle after acceptance.
- imem_req and imem_addr are combinational from state and pc, and are low/unchanged in IDLE and HALTED. They are gated low combinationally in any cycle where stall && if_valid.
- Redirect penalty: the first fetch of the target issues in the cycle after redir_valid, and if_valid is 0 for at least that cycle.
- Simultaneous stall and redirect: the redirect wins, and the flushed stage no longer blocks.
- Reset asserted mid-fetch or mid-stall: all state is cleared immediately; no pending request survives.

## Test plan
- Reset then free-run, imem_rdy=1, imem_rdata=16'hA000+addr:
  - imem_addr steps 0,1,2,...
  - if_valid high from cycle 3 with if_pc/if_instr matching.
- imem_rdy low 3 cycles at addr 5: imem_req stays 1 and imem_addr stays 5 for all 3 cycles; if_valid=0 over that window; PC advances to 6 only after acceptance.
- Stall 2 cycles with if_pc=4: if_instr/if_pc held, imem_req=0. Then redirect kind 00 to 16'h0040 arrives during the stall: the next fetch address is 16'h0040 and if_valid=0 for one cycle.
- Call depth test with RAS_DEPTH=4:
  - Five calls with links 10,20,30,40,50 give ras_count=4.
  - Five returns (ret_fallback=16'h0BAD) target 50,40,30,20, then 16'h0BAD, ending with ras_count=0.
- Halt same cycle as a redirect to 16'h0100:
  - halted=1, pc unchanged, imem_req=0 indefinitely.
  - rst_n pulse restores pc=RESET_PC and halted=0.
- Start PC 16'hFFFF (via redirect), free-run: fetch addresses 16'hFFFF then 16'h0000.
